// File: rtl/rr_arbiter_4ch_pkg.sv
// Shared constants and FSM state type for the 4-channel round-robin arbiter.
package rr_arbiter_4ch_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/arb_idx_decoder.sv
// Combinational index-to-one-hot decoder; output is all zero when disabled.
module arb_idx_decoder
   import rr_arbiter_4ch_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   input  logic             en_i,
   output logic [NREQ-1:0]  onehot_o
);

   // Single bit set at the index position, gated by enable
   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_4ch.sv
// Four-requester round-robin arbiter with hold-limit timeout and a
// mandatory one-cycle IDLE turnaround between grants.
module rr_arbiter_4ch
   import rr_arbiter_4ch_pkg::*;
#(
   parameter int MAX_HOLD = 15
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            en_i,
   input  logic [NREQ-1:0] req_i,
   input  logic            done_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic            gnt_vld_o,
   output logic            timeout_o
);

   localparam int HOLD_W = 8;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
      $error("MAX_HOLD must be in 1..255");
   end

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_e            state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  idx_q;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q;

   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  cand;
   logic              found;
   logic              at_limit;
   logic              release_req;

   // Rotating-priority scan: first set request starting at the pointer
   always_comb begin
      win_idx = ptr_q;
      cand    = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_q + IDX_W'(k);
         if (!found && req_i[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Exit conditions; a voluntary release outranks the hold limit for TIMEOUT
   always_comb begin
      at_limit    = (hold_q == HOLD_LAST);
      release_req = done_i | ~req_i[idx_q] | ~en_i;
      hold_d      = at_limit ? hold_q : hold_q + HOLD_W'(1);
   end

   // Arbiter FSM: state, pointer, hold counter, grant index and TIMEOUT pulse
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (en_i && (|req_i)) begin
                  state_q <= ST_GRANT;
                  idx_q   <= win_idx;
                  hold_q  <= '0;
               end
            end
            ST_GRANT: begin
               if (release_req || at_limit) begin
                  state_q   <= ST_IDLE;
                  ptr_q     <= idx_q + IDX_W'(1);
                  timeout_q <= at_limit && !release_req;
               end else begin
                  hold_q <= hold_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt_vld_o = (state_q == ST_GRANT);
   assign gnt_idx_o = idx_q;
   assign timeout_o = timeout_q;

   arb_idx_decoder u_dec (
      .idx_i    (idx_q),
      .en_i     (gnt_vld_o),
      .onehot_o (gnt_o)
   );

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// Scoreboard bench for rr_arbiter_4ch: a cycle-level reference model pushes
// expected outputs at each rising edge; a monitor pops and compares them on
// the falling edge.
module tb_rr_arbiter_4ch;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rr_arbiter_4ch #(.MAX_HOLD(MAXH)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .en_i      (en),
      .req_i     (req),
      .done_i    (done),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld),
      .timeout_o (timeout)
   );

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
      logic       to;
   } exp_t;

   exp_t sb[$];

   // Reference model: owner/pointer as plain integers, "held" counts grant
   // cycles already shown; a grant may be shown for at most MAXH cycles.
   bit m_act  = 0;
   int m_own  = 0;
   int m_ptr  = 0;
   int m_held = 0;
   bit m_to   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge rst_n) begin
      m_act = 0; m_own = 0; m_ptr = 0; m_held = 0; m_to = 0;
      sb.delete();
   end

   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         m_act = 0; m_own = 0; m_ptr = 0; m_held = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (!m_act) begin
            if (en && req != 4'b0000) begin
               for (int k = 0; k < 4; k++) begin
                  if (!m_act && req[(m_ptr + k) % 4]) begin
                     m_act  = 1;
                     m_own  = (m_ptr + k) % 4;
                     m_held = 1;
                  end
               end
            end
         end else begin
            bit vol;
            vol = done || !req[m_own] || !en;
            if (vol || m_held == MAXH) begin
               m_act = 0;
               m_ptr = (m_own + 1) % 4;
               m_to  = !vol;
            end else begin
               m_held++;
            end
         end
      end
      e.vld = m_act;
      e.idx = 2'(m_own);
      e.gnt = m_act ? (4'b0001 << m_own) : 4'b0000;
      e.to  = m_to;
      sb.push_back(e);
   end

   // Monitor: compare DUT outputs against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("gnt", gnt, e.gnt);
         chk("gnt_vld", gnt_vld, e.vld);
         chk("timeout", timeout, e.to);
         if (e.vld) chk("gnt_idx", gnt_idx, e.idx);
      end
   end

   task automatic drive(input logic e, input logic [3:0] r, input logic d);
      @(negedge clk);
      #1;
      en = e; req = r; done = d;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; req = 4'b0000; done = 1'b0;
      repeat (3) drive(0, 4'b0000, 0);
      @(negedge clk); #1 rst_n = 1'b1;

      // Basic grant / release with DONE, pointer advance to idx3
      drive(1, 4'b1010, 0);
      drive(1, 4'b1010, 0);
      drive(1, 4'b1010, 1);
      drive(1, 4'b1010, 0);
      drive(1, 4'b1010, 0);
      drive(1, 4'b1010, 1);
      repeat (2) drive(0, 4'b0000, 0);

      // All requesting, DONE held: rotating order with IDLE gaps
      repeat (12) drive(1, 4'b1111, 1);
      repeat (2) drive(0, 4'b0000, 0);

      // Sole requester held: timeout and re-grant
      repeat (14) drive(1, 4'b0001, 0);
      repeat (2) drive(0, 4'b0000, 0);

      // Two requesters: timeout hands over to idx1
      repeat (14) drive(1, 4'b0011, 0);
      repeat (2) drive(0, 4'b0000, 0);

      // DONE coincides with the last allowed grant cycle: no TIMEOUT
      drive(1, 4'b0011, 0);
      repeat (3) drive(1, 4'b0011, 0);
      drive(1, 4'b0011, 1);
      repeat (2) drive(0, 4'b0000, 0);

      // EN dropped mid-grant on idx2, then idx0 wins from pointer 3
      repeat (3) drive(1, 4'b0100, 0);
      drive(0, 4'b0100, 0);
      repeat (2) drive(0, 4'b0101, 0);
      repeat (3) drive(1, 4'b0101, 0);
      repeat (2) drive(0, 4'b0000, 0);

      // Asynchronous reset mid-grant
      repeat (3) drive(1, 4'b0100, 0);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("async_rst_gnt", gnt, 0);
      chk("async_rst_vld", gnt_vld, 0);
      chk("async_rst_to", timeout, 0);
      repeat (2) drive(1, 4'b0100, 0);
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (4) drive(1, 4'b0100, 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] r;
         r = req;
         if ($urandom_range(3) == 0) r = 4'($urandom);
         drive($urandom_range(15) != 0, r, $urandom_range(5) == 0);
      end

      repeat (3) @(negedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4ch.md
Name: rr_arbiter_4ch

Overview:
- Four-requester round-robin arbiter that shares one resource and drives a one-hot grant.
- It tracks a rotating priority pointer and holds each grant until release, request drop, disable or hold-limit timeout.
- The grant index is registered and expanded to one-hot by an instantiated 2-to-4 index decoder.
- Sits between four bus masters and a shared slave-select path.

Parameters:
- MAX_HOLD, 15, maximum consecutive cycles a single grant may be held; legal range 1..255.
- HOLD_W, 8, hold counter width; localparam, must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  arbiter enable; low forces all grants off
- REQ  input  4  request per requester, level-sensitive, bit i = requester i
- DONE  input  1  current grant holder releases the resource (single-cycle or level)
- GNT  output  4  one-hot grant, 4'b0000 when no grant
- GNT_IDX  output  2  index of granted requester; valid only when GNT_VLD=1
- GNT_VLD  output  1  a grant is active
- TIMEOUT  output  1  one-cycle pulse: grant revoked by the hold limit

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, pointer=0, HOLD_CNT=0, GNT_IDX=0, GNT_VLD=0, GNT=0000, TIMEOUT=0.
- Release of RST_N takes effect at the next CLK edge.
- States:
  - IDLE: no grant.
  - GRANT: GNT_VLD=1, GNT = decode(GNT_IDX).
- IDLE -> GRANT when EN=1 and REQ!=0 at a CLK edge.
  - Winner = first requester with REQ bit set, scanning pointer, pointer+1, ... mod 4.
  - GNT_IDX and GNT_VLD are registered, so latency is 1 cycle from sampled request to grant.
  - HOLD_CNT is cleared to 0 on entry.
- In GRANT, HOLD_CNT increments each cycle and saturates at MAX_HOLD-1.
- Exit GRANT -> IDLE at the edge where any of these holds: DONE=1, REQ[GNT_IDX]=0, EN=0, or HOLD_CNT==MAX_HOLD-1.
  - A grant therefore lasts at most MAX_HOLD cycles.
- On every exit: pointer = GNT_IDX+1 mod 4.
- Every exit passes through at least one IDLE cycle, with GNT=0000 for one turnaround cycle. There is no back-to-back grant.
- TIMEOUT=1 during the first IDLE cycle only when the exit was caused solely by the hold limit (DONE=0, REQ[GNT_IDX]=1, EN=1). Otherwise TIMEOUT=0.
- Simultaneous exit conditions: DONE, request drop or EN=0 take precedence, so TIMEOUT=0.
- A requester whose grant was revoked by timeout may be re-granted after the IDLE cycle if it is still the first requester from the updated pointer, including when it is the only requester.
- While EN=0: the IDLE -> GRANT transition is blocked. Pointer and REQ history are retained.
- REQ changes on non-granted bits during GRANT have no effect until the next arbitration.
- GNT is always the decode of GNT_IDX gated by GNT_VLD. At most one bit is ever high. GNT=0000 whenever GNT_VLD=0.
- MAX_HOLD=1 yields single-cycle grants with rotation every two cycles.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=1'b0, ST_GRANT=1'b1;
  - NREQ=4;
  - index width IDX_W=2.
- Sub-module arb_idx_decoder: purely combinational 2-bit index plus enable to 4-bit one-hot; enable tied to GNT_VLD.
- The main module holds the state register, pointer, hold counter, priority scan and TIMEOUT register.

Test Plan:
1. Reset, EN=1, REQ=1010 -> next cycle GNT=0010, GNT_IDX=1. Then DONE pulse -> one cycle GNT=0000, next cycle GNT=1000, GNT_IDX=3.
2. REQ=1111 held, DONE pulsed each grant cycle -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
3. MAX_HOLD=4, REQ=0001 held, no DONE -> GNT=0001 for exactly 4 cycles, then GNT=0000 with TIMEOUT=1 for 1 cycle, then GNT=0001 again.
4. MAX_HOLD=4, REQ=0011, no DONE -> idx0 held 4 cycles, TIMEOUT pulse, idx1 granted. Also DONE coinciding with the 4th cycle -> TIMEOUT=0.
5. Grant active on idx2, EN dropped -> GNT=0000 next cycle, TIMEOUT=0, pointer=3. EN restored with REQ=0101 -> idx0 granted.
6. RST_N asserted mid-grant (GNT=0100) -> GNT=0000 and GNT_VLD=0 immediately without a clock. After release with REQ=0100 -> grant to idx2, reached by scanning from pointer 0.
